risci_ifetch: RTL and testbench

RISCI_IFETCH -- requirements
Module: risci_ifetch

---
 rtl/risci_ifetch.sv | 125 ++++++++++++
 tb/tb_risci_ifetch.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/risci_ifetch.sv
// Instruction fetch front end: issues in-order fetch requests under a credit
// limit, buffers responses in a small queue toward decode, and handles
// redirects by flushing the queue and discarding stale in-flight responses.
module risci_ifetch #(
    parameter int unsigned     VLEN     = 64,
    parameter int unsigned     ILEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [VLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hlt,
    output logic            imem_req,
    output logic [VLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [VLEN-1:0] redirect_pc,
    output logic            inst_valid,
    output logic [ILEN-1:0] inst,
    output logic [VLEN-1:0] inst_pc,
    input  logic            inst_ready
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    state_t          state_q, state_d;
    logic [VLEN-1:0] pc_q;        // next fetch address
    logic [VLEN-1:0] rsp_pc_q;    // address belonging to the next accepted response
    logic [CW-1:0]   outst_q;     // granted requests whose response is still wanted
    logic [CW-1:0]   discard_q;   // granted requests whose response must be dropped
    logic [CW-1:0]   occ_q;
    logic [AW-1:0]   wptr_q, rptr_q;
    logic            pend_q;      // request was up last cycle and not granted

    logic [ILEN-1:0] mem_inst [DEPTH];
    logic [VLEN-1:0] mem_pc   [DEPTH];

    logic            xfer, rsp_drop, rsp_ok, rsp_push, pop, credit;
    logic [CW-1:0]   discard_new;
    logic [VLEN-1:0] redir_al;

    assign imem_addr = pc_q;
    assign inst      = mem_inst[rptr_q];
    assign inst_pc   = mem_pc[rptr_q];
    assign redir_al  = redirect_pc & ~VLEN'(3);
    assign credit    = ({1'b0, outst_q} + {1'b0, occ_q}) < DEPTH_W;

    // Handshake decode, outputs and next state
    always_comb begin
        imem_req    = 1'b0;
        inst_valid  = 1'b0;
        state_d     = state_q;
        // a pending request is held regardless of hlt; credit covers it already
        imem_req    = !rst && (state_q == RUN) && (pend_q || (!hlt && credit));
        inst_valid  = !rst && (occ_q != '0) && !redirect;
        xfer        = imem_req && imem_gnt;
        pop         = inst_valid && inst_ready;
        rsp_drop    = imem_rvalid && (discard_q != '0);
        rsp_ok      = imem_rvalid && (discard_q == '0) && (outst_q != '0);
        rsp_push    = rsp_ok && !redirect;
        // outstanding and discard are never both non-zero, so the sum fits
        discard_new = outst_q + discard_q + CW'(xfer) - CW'(rsp_drop || rsp_ok);

        unique case (state_q)
            RUN:     if (hlt && (!imem_req || imem_gnt)) state_d = HALT;
            DRAIN:   if (discard_q <= CW'(rsp_drop)) state_d = RUN;
            HALT:    if (!hlt) state_d = (discard_q > CW'(rsp_drop)) ? DRAIN : RUN;
            default: state_d = RUN;
        endcase

        if (redirect) begin
            if (state_q == HALT && hlt) state_d = HALT;
            else                        state_d = (discard_new != '0) ? DRAIN : RUN;
        end
    end

    // Control state, counters and queue pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            rsp_pc_q  <= RESET_PC;
            outst_q   <= '0;
            discard_q <= '0;
            occ_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            pend_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= imem_req && !imem_gnt && !redirect;
            if (redirect) begin
                pc_q      <= redir_al;
                rsp_pc_q  <= redir_al;
                outst_q   <= '0;
                discard_q <= discard_new;
                occ_q     <= '0;
                wptr_q    <= '0;
                rptr_q    <= '0;
            end else begin
                if (xfer)   pc_q     <= pc_q + VLEN'(4);
                if (rsp_ok) rsp_pc_q <= rsp_pc_q + VLEN'(4);
                outst_q   <= outst_q + CW'(xfer) - CW'(rsp_ok);
                discard_q <= discard_q - CW'(rsp_drop);
                occ_q     <= occ_q + CW'(rsp_push) - CW'(pop);
                if (rsp_push) wptr_q <= wptr_q + AW'(1);
                if (pop)      rptr_q <= rptr_q + AW'(1);
            end
        end
    end

    // Queue storage; contents need no reset since occupancy gates validity
    always_ff @(posedge clk) begin
        if (!rst && rsp_push) begin
            mem_inst[wptr_q] <= imem_rdata;
            mem_pc[wptr_q]   <= rsp_pc_q;
        end
    end

endmodule

// File: tb/tb_risci_ifetch.sv
// Bench for risci_ifetch: directed scenarios plus randomized traffic, all
// checked against a transaction-level model (address stream + queues).
module tb_risci_ifetch;
    localparam int VLEN = 64;
    localparam int ILEN = 32;
    localparam int DEPTH = 4;
    localparam logic [VLEN-1:0] RESET_PC = '0;

    logic clk = 1'b0;
    logic rst, hlt, imem_req, imem_gnt, imem_rvalid, redirect, inst_valid, inst_ready;
    logic [VLEN-1:0] imem_addr, redirect_pc, inst_pc;
    logic [ILEN-1:0] imem_rdata, inst;

    int checks = 0;
    int errors = 0;

    risci_ifetch #(.VLEN(VLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .hlt(hlt),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    // model: next fetch address, in-flight fetches (kind 0 ghost, 1 stale, 2 live), expected queue
    logic [VLEN-1:0] exp_pc;
    logic [VLEN-1:0] ifl_addr[$];
    int              ifl_kind[$];
    logic [VLEN-1:0] expq[$];
    bit              pend, prev_hlt;

    function automatic logic [ILEN-1:0] memword(input logic [VLEN-1:0] a);
        return a[31:0] ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // one clock: drive at negedge, check 1ns later, advance the model
    task automatic cyc(input bit g, input bit v, input bit rdy, input bit h, input bit rd,
                       input logic [VLEN-1:0] rp, input bit r, input bit ghosts);
        int stale = 0;
        int live = 0;
        int k;
        bit ev, xf;
        logic [VLEN-1:0] a;
        @(negedge clk);
        rst = r; hlt = h; imem_gnt = g; inst_ready = rdy; redirect = rd; redirect_pc = rp;
        imem_rvalid = v && (ifl_addr.size() != 0);
        imem_rdata  = imem_rvalid ? memword(ifl_addr[0]) : ILEN'($urandom);
        #1;
        if (r) begin
            chk("rst_req", imem_req, 0);
            chk("rst_valid", inst_valid, 0);
            if (imem_rvalid) begin
                void'(ifl_addr.pop_front());
                void'(ifl_kind.pop_front());
            end
            exp_pc = RESET_PC; expq.delete(); pend = 0; prev_hlt = h;
            if (ghosts) foreach (ifl_kind[i]) ifl_kind[i] = 0;
            else begin ifl_addr.delete(); ifl_kind.delete(); end
            return;
        end
        foreach (ifl_kind[i]) begin
            if (ifl_kind[i] == 1) stale++;
            if (ifl_kind[i] == 2) live++;
        end
        ev = (expq.size() != 0) && !rd;
        chk("inst_valid", inst_valid, ev);
        if (ev && rdy) begin
            chk("inst_pc", inst_pc, expq[0]);
            chk("inst", inst, memword(expq[0]));
        end
        if (pend)                                         chk("req_hold", imem_req, 1);
        else if (h || stale > 0 || live + expq.size() >= DEPTH) chk("req_off", imem_req, 0);
        else if (!prev_hlt)                               chk("req_on", imem_req, 1);
        if (imem_req) chk("imem_addr", imem_addr, exp_pc);

        xf = imem_req && g;
        if (ev && rdy) void'(expq.pop_front());
        if (imem_rvalid) begin
            a = ifl_addr.pop_front();
            k = ifl_kind.pop_front();
            if (k == 2 && !rd) expq.push_back(a);
        end
        if (xf) begin
            ifl_addr.push_back(exp_pc);
            ifl_kind.push_back(rd ? 1 : 2);
            exp_pc += 4;
        end
        if (rd) begin
            expq.delete();
            foreach (ifl_kind[i]) if (ifl_kind[i] == 2) ifl_kind[i] = 1;
            exp_pc = rp & ~64'h3;
        end
        pend = imem_req && !g && !rd;
        prev_hlt = h;
    endtask

    task automatic do_rst(input int n, input bit ghosts);
        repeat (n) cyc(0, 0, 0, 0, 0, '0, 1, ghosts);
    endtask

    task automatic run(input int n);
        repeat (n) cyc(1, 1, 1, 0, 0, '0, 0, 0);
    endtask

    logic [VLEN-1:0] held, rp;
    int n, hburst;
    bit g, v, rdy, h, rd, r;

    initial begin
        rst = 1; hlt = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        redirect = 0; redirect_pc = '0; inst_ready = 0;
        exp_pc = RESET_PC; pend = 0; prev_hlt = 0; hburst = 0;

        // streaming with single-cycle memory: sequential addresses, no gaps
        do_rst(2, 0);
        for (int i = 0; i < 30; i++) begin
            cyc(1, 1, 1, 0, 0, '0, 0, 0);
            if (i >= 2) chk("no_gap", inst_valid, 1);
        end

        // decode stalled: credit stops fetch with exactly DEPTH entries queued
        do_rst(1, 0);
        repeat (10) cyc(1, 1, 0, 0, 0, '0, 0, 0);
        chk("full_req", imem_req, 0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 1, 0, 0, '0, 0, 0);
            if (inst_valid) n++;
        end
        chk("q_entries", n, 4);

        // redirect with two fetches outstanding, unaligned target
        do_rst(1, 0);
        cyc(1, 0, 1, 0, 0, '0, 0, 0);
        cyc(1, 0, 1, 0, 0, '0, 0, 0);
        cyc(0, 0, 1, 0, 1, 64'h1003, 0, 0);
        cyc(0, 1, 1, 0, 0, '0, 0, 0); chk("drain_req0", imem_req, 0);
        cyc(0, 1, 1, 0, 0, '0, 0, 0); chk("drain_req1", imem_req, 0);
        chk("drain_valid", inst_valid, 0);
        cyc(1, 0, 1, 0, 0, '0, 0, 0);
        chk("redir_req", imem_req, 1);
        chk("redir_addr", imem_addr, 64'h1000);
        run(6);

        // redirect coinciding with grant and response, one outstanding
        do_rst(1, 0);
        cyc(1, 0, 1, 0, 0, '0, 0, 0);
        cyc(1, 1, 1, 0, 1, 64'h2000, 0, 0);
        cyc(0, 1, 1, 0, 0, '0, 0, 0);
        chk("drop_req", imem_req, 0);
        chk("drop_valid", inst_valid, 0);
        cyc(1, 1, 1, 0, 0, '0, 0, 0);
        chk("post_req", imem_req, 1);
        chk("post_addr", imem_addr, 64'h2000);
        cyc(0, 1, 1, 0, 0, '0, 0, 0);
        cyc(0, 0, 1, 0, 0, '0, 0, 0);
        chk("post_valid", inst_valid, 1);
        chk("post_pc", inst_pc, 64'h2000);

        // halt while a request waits for grant
        do_rst(1, 0);
        run(4);
        cyc(0, 1, 1, 0, 0, '0, 0, 0);
        held = imem_addr;
        chk("pre_req", imem_req, 1);
        repeat (2) begin
            cyc(0, 1, 1, 1, 0, '0, 0, 0);
            chk("hold_req", imem_req, 1);
            chk("hold_addr", imem_addr, held);
        end
        cyc(1, 1, 1, 1, 0, '0, 0, 0);
        chk("hold_gnt", imem_req, 1);
        repeat (3) begin
            cyc(1, 1, 1, 1, 0, '0, 0, 0);
            chk("halt_req", imem_req, 0);
        end
        cyc(1, 1, 1, 0, 0, '0, 0, 0);
        cyc(1, 1, 1, 0, 0, '0, 0, 0);
        chk("resume_req", imem_req, 1);
        chk("resume_addr", imem_addr, held + 64'd4);
        run(4);

        // reset with three fetches in flight; late responses are ignored
        do_rst(1, 0);
        repeat (3) cyc(1, 0, 0, 0, 0, '0, 0, 0);
        do_rst(2, 1);
        repeat (3) begin
            cyc(0, 1, 1, 0, 0, '0, 0, 0);
            chk("ghost_valid", inst_valid, 0);
            chk("restart_addr", imem_addr, RESET_PC);
        end
        run(8);

        // address wrap at the top of the address space
        do_rst(1, 0);
        cyc(0, 0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFF9, 0, 0);
        cyc(1, 1, 1, 0, 0, '0, 0, 0);
        chk("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        run(8);

        // randomized traffic
        do_rst(1, 0);
        for (int i = 0; i < 4000; i++) begin
            g   = $urandom_range(0, 9) < 7;
            v   = $urandom_range(0, 9) < 6;
            rdy = $urandom_range(0, 9) < 7;
            if (hburst == 0 && $urandom_range(0, 39) == 0) hburst = $urandom_range(1, 8);
            h = (hburst > 0);
            if (hburst > 0) hburst--;
            rd = ($urandom_range(0, 29) == 0);
            rp = ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom)}
                                             : {32'($urandom), 32'($urandom)};
            r = ($urandom_range(0, 499) == 0);
            cyc(g, v, rdy, h, rd, rp, r, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
